// File: rtl/unsigned_accumulator_pkg.sv
// rtl/unsigned_accumulator_pkg.sv - shared state encoding and product width for the product accumulator
package unsigned_accumulator_pkg;

  // Width of the products delivered by the upstream 4x4 multiplier
  localparam int PRODUCT_WIDTH = 8;

  // Job sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Count loaded for a job; a zero length field stands for the full 2^cw range
  function automatic logic [32:0] job_count(input logic [31:0] len, input int cw);
    job_count = (len == 32'd0) ? (33'd1 << cw) : {1'b0, len};
  endfunction

endpackage

// File: rtl/unsigned_sat_adder.sv
// rtl/unsigned_sat_adder.sv - accumulator adder with carry detect; clamps when UNSIGNED_ACCUMULATOR_SATURATE_EN is defined
module unsigned_sat_adder
  import unsigned_accumulator_pkg::*;
#(
  parameter int ACC_WIDTH = 10
) (
  input  logic [ACC_WIDTH-1:0]     acc_i,
  input  logic [PRODUCT_WIDTH-1:0] addend_i,
  output logic [ACC_WIDTH-1:0]     sum_o,
  output logic                     carry_o
);

  logic [ACC_WIDTH:0] sum_full_d;

  // One extra bit holds the carry out of the accumulator width
  always_comb begin
    sum_full_d = {1'b0, acc_i} + {{(ACC_WIDTH + 1 - PRODUCT_WIDTH){1'b0}}, addend_i};
    carry_o    = sum_full_d[ACC_WIDTH];
`ifdef UNSIGNED_ACCUMULATOR_SATURATE_EN
    // Once at full scale any nonzero addend carries again, so the sum stays pinned
    sum_o      = carry_o ? {ACC_WIDTH{1'b1}} : sum_full_d[ACC_WIDTH-1:0];
`else
    sum_o      = sum_full_d[ACC_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/unsigned_product_accumulator.sv
// rtl/unsigned_product_accumulator.sv - sums a counted job of 8-bit products; optional clamp via UNSIGNED_ACCUMULATOR_SATURATE_EN
module unsigned_product_accumulator
  import unsigned_accumulator_pkg::*;
#(
  parameter int ACC_WIDTH   = 10,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                     Clock_In,
  input  logic                     Reset_In,
  input  logic                     Start_In,
  input  logic [COUNT_WIDTH-1:0]   Length_In,
  input  logic                     Product_Valid_In,
  input  logic [PRODUCT_WIDTH-1:0] Product_In,
  output logic                     Product_Ready_Out,
  output logic                     Result_Valid_Out,
  input  logic                     Result_Ready_In,
  output logic [ACC_WIDTH-1:0]     Result_Out,
  output logic                     Overflow_Out,
  output logic                     Busy_Out
);

  state_e                 state_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   result_q;
  logic                   overflow_q;
  logic [COUNT_WIDTH:0]   count_q;
  logic                   ready_q;
  logic                   valid_q;
  logic                   busy_q;

  logic [ACC_WIDTH-1:0]   sum_d;
  logic                   carry_d;
  logic [COUNT_WIDTH:0]   count_load_d;
  logic [32:0]            count_full_d;
  logic                   last_d;

  unsigned_sat_adder #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_adder (
    .acc_i    (acc_q),
    .addend_i (Product_In),
    .sum_o    (sum_d),
    .carry_o  (carry_d)
  );

  // Job length decode and last-product detect
  always_comb begin
    count_full_d = job_count(32'(Length_In), COUNT_WIDTH);
    count_load_d = count_full_d[COUNT_WIDTH:0];
    last_d       = (count_q == {{COUNT_WIDTH{1'b0}}, 1'b1});
  end

  // Sequencer with registered handshake outputs; result register only loads at job end
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start_In) begin
            acc_q      <= '0;
            overflow_q <= 1'b0;
            count_q    <= count_load_d;
            state_q    <= ACCUM;
            ready_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (Product_Valid_In) begin
            acc_q      <= sum_d;
            overflow_q <= overflow_q | carry_d;
            count_q    <= count_q - 1'b1;
            if (last_d) begin
              result_q <= sum_d;
              state_q  <= DONE;
              ready_q  <= 1'b0;
              valid_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          // Start_In is deliberately not looked at here, even on the handshake cycle
          if (Result_Ready_In) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Product_Ready_Out = ready_q;
  assign Result_Valid_Out  = valid_q;
  assign Result_Out        = result_q;
  assign Overflow_Out      = overflow_q;
  assign Busy_Out          = busy_q;

endmodule

// File: tb/tb_unsigned_product_accumulator.sv
// tb/tb_unsigned_product_accumulator.sv - randomized self-checking bench for the product accumulator
module tb_unsigned_product_accumulator;

  localparam int     AW   = 10;
  localparam int     CW   = 4;
  localparam longint MAXV = (64'd1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] len;
  logic          pvalid;
  logic [7:0]    product;
  logic          pready;
  logic          rvalid;
  logic          rready;
  logic [AW-1:0] result;
  logic          ovf;
  logic          busy;

  int checks = 0;
  int errors = 0;

  int     prod_q[$];
  longint exp_res;
  bit     exp_ovf;

  always #5 clk = ~clk;

  unsigned_product_accumulator #(
    .ACC_WIDTH   (AW),
    .COUNT_WIDTH (CW)
  ) dut (
    .Clock_In          (clk),
    .Reset_In          (rst),
    .Start_In          (start),
    .Length_In         (len),
    .Product_Valid_In  (pvalid),
    .Product_In        (product),
    .Product_Ready_Out (pready),
    .Result_Valid_Out  (rvalid),
    .Result_Ready_In   (rready),
    .Result_Out        (result),
    .Overflow_Out      (ovf),
    .Busy_Out          (busy)
  );

  // Reference: true sum of the job, then wrap or clamp
  task automatic model_expect();
    longint total = 0;
    foreach (prod_q[i]) total += prod_q[i];
    exp_ovf = (total > MAXV);
`ifdef UNSIGNED_ACCUMULATOR_SATURATE_EN
    exp_res = exp_ovf ? MAXV : total;
`else
    exp_res = total % (MAXV + 1);
`endif
  endtask

  // Starts a job and feeds prod_q with random bubbles until the result appears
  task automatic drive_job(input int len_field, input int bubble_pct,
                           output int xfers, output int lat, output bit timeout);
    int idx = 0;
    int cyc = 0;
    int lastx = -100;
    xfers = 0;
    @(negedge clk);
    start = 1'b1;
    len   = CW'(len_field);
    @(negedge clk);
    start = 1'b0;
    while (!rvalid && cyc < 3000) begin
      if (idx < prod_q.size() && $urandom_range(99) >= bubble_pct) begin
        pvalid  = 1'b1;
        product = 8'(prod_q[idx]);
      end else begin
        pvalid  = 1'b0;
        product = 8'($urandom_range(255));
      end
      if (pvalid && pready) begin
        xfers++;
        idx++;
        lastx = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    pvalid  = 1'b0;
    timeout = !rvalid;
    lat     = cyc - lastx;
  endtask

  task automatic handshake(input int delay);
    repeat (delay) @(negedge clk);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
    checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0b want 0", rvalid); end
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready got %0b want 0", pready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int x, l; bit to;
    prod_q = '{15, 200, 7};
    drive_job(3, 0, x, l, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got %0b want 0", to); end
    checks++; if (x != 3) begin errors++; $display("FAIL basic_xfers got %0d want 3", x); end
    checks++; if (l != 1) begin errors++; $display("FAIL basic_latency got %0d want 1", l); end
    checks++; if (result !== 10'd222) begin errors++; $display("FAIL basic_result got %0d want 222", result); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %0b want 0", ovf); end
    handshake(0);
    checks++; if (busy !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("FAIL basic_idle busy %0b rvalid %0b want 0 0", busy, rvalid); end
  endtask

  task automatic test_overflow();
    int x, l; bit to;
    longint want;
`ifdef UNSIGNED_ACCUMULATOR_SATURATE_EN
    want = 1023;
`else
    want = 101;
`endif
    prod_q = '{225, 225, 225, 225, 225};
    drive_job(5, 0, x, l, to);
    checks++; if (to !== 1'b0 || x != 5) begin errors++; $display("FAIL ovf_xfers got %0d timeout %0b want 5 0", x, to); end
    checks++; if (64'(result) != want) begin errors++; $display("FAIL ovf_result got %0d want %0d", result, want); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", ovf); end
    handshake(1);
  endtask

  task automatic test_length_zero();
    int x, l; bit to;
    prod_q.delete();
    repeat (16) prod_q.push_back(1);
    drive_job(0, 40, x, l, to);
    checks++; if (to !== 1'b0 || x != 16) begin errors++; $display("FAIL len0_xfers got %0d timeout %0b want 16 0", x, to); end
    checks++; if (result !== 10'd16) begin errors++; $display("FAIL len0_result got %0d want 16", result); end
    checks++; if (l != 1) begin errors++; $display("FAIL len0_latency got %0d want 1", l); end
    handshake(0);
  endtask

  task automatic test_backpressure();
    int x, l; bit to;
    prod_q.delete();
    repeat (4) prod_q.push_back($urandom_range(255));
    model_expect();
    drive_job(4, 20, x, l, to);
    checks++; if (to !== 1'b0 || x != 4) begin errors++; $display("FAIL bp_xfers got %0d timeout %0b want 4 0", x, to); end
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0);
      len   = 4'd2;
      checks++;
      if (rvalid !== 1'b1 || busy !== 1'b1 || pready !== 1'b0 || 64'(result) != exp_res || ovf !== exp_ovf) begin
        errors++;
        $display("FAIL bp_hold cycle %0d rvalid %0b busy %0b pready %0b result %0d ovf %0b want 1 1 0 %0d %0b",
                 i, rvalid, busy, pready, result, ovf, exp_res, exp_ovf);
      end
      @(negedge clk);
    end
    start = 1'b0;
    handshake(0);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rvalid !== 1'b0 || pready !== 1'b0) begin errors++; $display("FAIL bp_idle busy %0b rvalid %0b pready %0b want 0 0 0", busy, rvalid, pready); end
    checks++; if (64'(result) != exp_res) begin errors++; $display("FAIL bp_retain got %0d want %0d", result, exp_res); end
  endtask

  task automatic test_reset_midjob();
    int x, l; bit to;
    @(negedge clk);
    start = 1'b1;
    len   = 4'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pvalid  = 1'b1;
      product = 8'($urandom_range(1, 255));
      @(negedge clk);
    end
    pvalid = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    checks++;
    if (result !== '0 || ovf !== 1'b0 || rvalid !== 1'b0 || pready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset result %0d ovf %0b rvalid %0b pready %0b busy %0b want all 0", result, ovf, rvalid, pready, busy);
    end
    rst = 1'b0;
    prod_q = '{9};
    drive_job(1, 0, x, l, to);
    checks++; if (to !== 1'b0 || result !== 10'd9 || ovf !== 1'b0) begin errors++; $display("FAIL midreset_newjob result %0d ovf %0b timeout %0b want 9 0 0", result, ovf, to); end
    handshake(0);
  endtask

  task automatic test_back_to_back();
    int x, l; bit to;
    prod_q.delete();
    repeat (3) prod_q.push_back($urandom_range(255));
    model_expect();
    drive_job(3, 0, x, l, to);
    checks++; if (to !== 1'b0 || 64'(result) != exp_res) begin errors++; $display("FAIL b2b_first result %0d want %0d", result, exp_res); end
    start  = 1'b1;
    len    = 4'd2;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    checks++; if (busy !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("FAIL b2b_gap busy %0b rvalid %0b want 0 0", busy, rvalid); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || pready !== 1'b1) begin errors++; $display("FAIL b2b_restart busy %0b pready %0b want 1 1", busy, pready); end
    prod_q.delete();
    repeat (2) prod_q.push_back($urandom_range(255));
    model_expect();
    foreach (prod_q[i]) begin
      pvalid  = 1'b1;
      product = 8'(prod_q[i]);
      @(negedge clk);
    end
    pvalid = 1'b0;
    start  = 1'b0;
    checks++; if (rvalid !== 1'b1 || 64'(result) != exp_res || ovf !== exp_ovf) begin errors++; $display("FAIL b2b_second rvalid %0b result %0d ovf %0b want 1 %0d %0b", rvalid, result, ovf, exp_res, exp_ovf); end
    handshake(0);
  endtask

  task automatic test_random();
    int x, l, n; bit to;
    for (int j = 0; j < 20; j++) begin
      n = $urandom_range(1, 16);
      prod_q.delete();
      for (int k = 0; k < n; k++) prod_q.push_back((j % 3 == 0) ? $urandom_range(200, 255) : $urandom_range(255));
      model_expect();
      drive_job(n % 16, 30, x, l, to);
      checks++;
      if (to !== 1'b0 || x != n || l != 1 || 64'(result) != exp_res || ovf !== exp_ovf) begin
        errors++;
        $display("FAIL random job %0d xfers %0d lat %0d result %0d ovf %0b timeout %0b want %0d 1 %0d %0b 0",
                 j, x, l, result, ovf, to, n, exp_res, exp_ovf);
      end
      handshake($urandom_range(3));
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    len     = '0;
    pvalid  = 1'b0;
    product = '0;
    rready  = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_length_zero();
    test_backpressure();
    test_reset_midjob();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
